mem_access_unit: RTL and testbench

//  MEM-stage consumer of the EXE/MEM pipeline register. Decodes the 4-bit memory op,

---
 rtl/mem_access_unit_pkg.sv | 49 ++++
 rtl/mem_align.sv | 62 ++++++
 rtl/mem_access_unit.sv | 155 +++++++++++++++
 tb/tb_mem_access_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: memory op codes, FSM states
// and op-decoding helpers.
package mem_access_unit_pkg;

  typedef enum logic [3:0] {
    MEM_NOP_OP = 4'd0,
    MEM_LB_OP  = 4'd1,
    MEM_LH_OP  = 4'd2,
    MEM_LW_OP  = 4'd3,
    MEM_LBU_OP = 4'd4,
    MEM_LHU_OP = 4'd5,
    MEM_SB_OP  = 4'd6,
    MEM_SH_OP  = 4'd7,
    MEM_SW_OP  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
  localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

  function automatic logic is_load(input logic [3:0] op);
    case (op)
      MEM_LB_OP, MEM_LH_OP, MEM_LW_OP, MEM_LBU_OP, MEM_LHU_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    case (op)
      MEM_SB_OP, MEM_SH_OP, MEM_SW_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Byte accesses can never be misaligned; halves need bit 0 clear, words both bits.
  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
    case (op)
      MEM_LH_OP, MEM_LHU_OP, MEM_SH_OP: return off[0];
      MEM_LW_OP, MEM_SW_OP:             return off != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data steering: store lane replication / byte enables, and
// load byte/half extraction with sign or zero extension.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [3:0]  st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  input  logic [3:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] sb_wdata;
  logic [31:0] sh_wdata;
  logic [7:0]  ld_bytes [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign sb_wdata[gi*8 +: 8] = st_data[7:0];
      assign sh_wdata[gi*8 +: 8] = st_data[(gi%2)*8 +: 8];
      assign ld_bytes[gi]        = ld_rdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_op)
      MEM_SB_OP: begin
        st_wdata = sb_wdata;
        st_be    = 4'b0001 << st_off;
      end
      MEM_SH_OP: begin
        st_wdata = sh_wdata;
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign byte_sel = ld_bytes[ld_off];
  assign half_sel = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_data = ld_rdata;
    case (ld_op)
      MEM_LB_OP:  ld_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU_OP: ld_data = {24'h0, byte_sel};
      MEM_LH_OP:  ld_data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU_OP: ld_data = {16'h0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage access unit: runs one req/ack data-memory transaction per load/store,
// stalls the pipeline while it is outstanding, and registers the MEM/WB result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_pc,
  input  logic [3:0]  mem_mem_op,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_mem_data,
  input  logic        mem_we,
  input  logic [4:0]  mem_write_reg,
  input  logic [31:0] mem_write_data,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_req,
  output logic [31:0] wb_pc,
  output logic        wb_we,
  output logic [4:0]  wb_write_reg,
  output logic [31:0] wb_write_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       op_reg;
  logic [1:0]       off_reg;
  logic [31:0]      pc_reg;
  logic             we_reg;
  logic [4:0]       dst_reg;
  logic [31:0]      alu_reg;
  logic [31:0]      rdata_reg;
  logic             timeout_reg;

  logic        in_mem;
  logic        in_misaligned;
  logic        in_store;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  assign in_store      = is_store(mem_mem_op);
  assign in_mem        = is_load(mem_mem_op) || in_store;
  assign in_misaligned = in_mem && is_misaligned(mem_mem_op, mem_mem_addr[1:0]);

  // Stall from the moment an aligned access is presented until the bus completes;
  // DONE releases the pipeline so the instruction retires on the same edge.
  assign stall_req = (state_reg == ST_BUSY) ||
                     ((state_reg == ST_IDLE) && in_mem && !in_misaligned);

  mem_align u_align (
    .st_op    (mem_mem_op),
    .st_off   (mem_mem_addr[1:0]),
    .st_data  (mem_mem_data),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .ld_op    (op_reg),
    .ld_off   (off_reg),
    .ld_rdata (dmem_rdata),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      op_reg        <= MEM_NOP_OP;
      off_reg       <= 2'b00;
      pc_reg        <= ZERO_WORD;
      we_reg        <= 1'b0;
      dst_reg       <= NOP_REG_ADDR;
      alu_reg       <= ZERO_WORD;
      rdata_reg     <= ZERO_WORD;
      timeout_reg   <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_wr       <= 1'b0;
      dmem_addr     <= ZERO_WORD;
      dmem_wdata    <= ZERO_WORD;
      dmem_be       <= 4'b0000;
      wb_pc         <= ZERO_WORD;
      wb_we         <= 1'b0;
      wb_write_reg  <= NOP_REG_ADDR;
      wb_write_data <= ZERO_WORD;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (in_mem && !in_misaligned) begin
            dmem_req    <= 1'b1;
            dmem_wr     <= in_store;
            dmem_addr   <= {mem_mem_addr[31:2], 2'b00};
            dmem_wdata  <= st_wdata;
            dmem_be     <= st_be;
            op_reg      <= mem_mem_op;
            off_reg     <= mem_mem_addr[1:0];
            pc_reg      <= mem_pc;
            we_reg      <= mem_we;
            dst_reg     <= mem_write_reg;
            alu_reg     <= mem_write_data;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
            wb_we       <= 1'b0;
            state_reg   <= ST_BUSY;
          end else begin
            // Misaligned accesses retire as a bubble; everything else passes through.
            wb_pc         <= mem_pc;
            wb_write_reg  <= mem_write_reg;
            wb_write_data <= mem_write_data;
            wb_we         <= in_mem ? 1'b0 : mem_we;
            misalign_err  <= in_misaligned;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            rdata_reg <= ld_data;
            state_reg <= ST_DONE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_reg == CNT_LAST)) begin
            dmem_req    <= 1'b0;
            rdata_reg   <= ZERO_WORD;
            timeout_reg <= 1'b1;
            bus_err     <= 1'b1;
            state_reg   <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          wb_pc         <= pc_reg;
          wb_write_reg  <= dst_reg;
          wb_we         <= timeout_reg ? 1'b0 : we_reg;
          wb_write_data <= is_load(op_reg) ? rdata_reg : alu_reg;
          state_reg     <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against a byte-addressed
// memory model and arithmetic expectations for lanes, enables and extension.
module tb_mem_access_unit;

  localparam int TO = 4;
  localparam logic [3:0] OP_NOP = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                         OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7,
                         OP_SW = 4'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_pc, mem_mem_addr, mem_mem_data, mem_write_data;
  logic [3:0]  mem_mem_op;
  logic        mem_we;
  logic [4:0]  mem_write_reg;
  logic        dmem_req, dmem_wr, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stall_req, wb_we, misalign_err, bus_err;
  logic [31:0] wb_pc, wb_write_data;
  logic [4:0]  wb_write_reg;

  int n_vec  = 0;
  int n_miss = 0;
  int n_txn  = 0;
  logic [31:0] mem_model [int];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .mem_pc(mem_pc), .mem_mem_op(mem_mem_op),
    .mem_mem_addr(mem_mem_addr), .mem_mem_data(mem_mem_data), .mem_we(mem_we),
    .mem_write_reg(mem_write_reg), .mem_write_data(mem_write_data),
    .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_req(stall_req), .wb_pc(wb_pc), .wb_we(wb_we),
    .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (txn %0d, t=%0t)", tag, got, exp, n_txn, $time);
    end
  endtask

  function automatic bit is_ld(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LHU);
  endfunction

  function automatic bit is_st(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] a);
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
    if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * (a % 4));
    case (op)
      OP_LB:   return 32'($signed(sh[7:0]));
      OP_LBU:  return sh & 32'h0000_00FF;
      OP_LH:   return 32'($signed(sh[15:0]));
      OP_LHU:  return sh & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_be(input logic [3:0] op, input logic [31:0] a);
    if (op == OP_SB) return 4'(1 << (a % 4));
    if (op == OP_SH) return 4'(3 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [3:0] op, input logic [31:0] d);
    if (op == OP_SB) return (d & 32'hFF) * 32'h0101_0101;
    if (op == OP_SH) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] read_word(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    if (!mem_model.exists(idx)) mem_model[idx] = $urandom;
    return mem_model[idx];
  endfunction

  task automatic write_model(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] mask, w;
    mask = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    w = read_word(a);
    mem_model[int'(a >> 2)] = (w & ~mask) | (wd & mask);
  endtask

  task automatic drive_nop(input logic we);
    mem_mem_op = OP_NOP; mem_pc = $urandom; mem_mem_addr = $urandom;
    mem_mem_data = $urandom; mem_we = we; mem_write_reg = 5'($urandom);
    mem_write_data = $urandom;
  endtask

  // One instruction through MEM. delay = BUSY cycles without ack before ack.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] word, input int delay);
    logic [31:0] pc, alu;
    logic we, mis, ld, st, timed_out;
    logic [4:0] rd;
    int busy, stalls;
    pc = $urandom; alu = $urandom; we = 1'($urandom); rd = 5'($urandom);
    ld = is_ld(op); st = is_st(op); mis = misaligned(op, addr);
    timed_out = (delay >= TO);
    n_txn++;
    $display("txn %0d op=%0d addr=%h data=%h word=%h delay=%0d", n_txn, op, addr, data, word, delay);
    mem_mem_op = op; mem_mem_addr = addr; mem_mem_data = data; mem_pc = pc;
    mem_we = we; mem_write_reg = rd; mem_write_data = alu;
    dmem_ack = 1'($urandom); dmem_rdata = $urandom;
    #1;
    check_val("stall_idle", stall_req, (ld || st) && !mis);
    @(posedge clk); #1;
    if (!ld && !st) begin
      check_val("nop_pc", wb_pc, pc);
      check_val("nop_we", wb_we, we);
      check_val("nop_reg", wb_write_reg, rd);
      check_val("nop_data", wb_write_data, alu);
      check_val("nop_req", dmem_req, 0);
    end else if (mis) begin
      check_val("mis_err", misalign_err, 1);
      check_val("mis_we", wb_we, 0);
      check_val("mis_pc", wb_pc, pc);
      check_val("mis_reg", wb_write_reg, rd);
      check_val("mis_req", dmem_req, 0);
      check_val("mis_buserr", bus_err, 0);
      drive_nop(1'b0);
      @(posedge clk); #1;
      check_val("mis_pulse_end", misalign_err, 0);
    end else begin
      check_val("req", dmem_req, 1);
      check_val("wr", dmem_wr, st);
      check_val("addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check_val("be", dmem_be, exp_be(op, addr));
      if (st) check_val("wdata", dmem_wdata, exp_wdata(op, data));
      stalls = 1; busy = 0;
      while (dmem_req === 1'b1 && busy < 40) begin
        stalls += int'(stall_req);
        if (busy == delay) begin
          dmem_ack = 1'b1; dmem_rdata = word;
        end else begin
          dmem_ack = 1'b0; dmem_rdata = $urandom;
        end
        mem_mem_op = 4'($urandom_range(0, 8)); mem_mem_addr = $urandom;
        mem_mem_data = $urandom; mem_pc = $urandom; mem_we = 1'($urandom);
        mem_write_reg = 5'($urandom); mem_write_data = $urandom;
        @(posedge clk); #1;
        busy++;
      end
      dmem_ack = 1'b0;
      mem_mem_op = op; mem_mem_addr = addr; mem_mem_data = data; mem_pc = pc;
      mem_we = we; mem_write_reg = rd; mem_write_data = alu;
      #1;
      check_val("stall_done", stall_req, 0);
      check_val("bus_err", bus_err, timed_out);
      if (timed_out) begin
        check_val("timeout_cycles", busy, TO);
      end else begin
        check_val("busy_cycles", busy, delay + 1);
        check_val("stall_cycles", stalls, delay + 2);
      end
      @(posedge clk); #1;
      check_val("wb_pc", wb_pc, pc);
      check_val("wb_reg", wb_write_reg, rd);
      check_val("wb_we", wb_we, timed_out ? 1'b0 : we);
      check_val("bus_err_end", bus_err, 0);
      if (!timed_out)
        check_val("wb_data", wb_write_data, ld ? exp_load(op, addr, word) : alu);
      if (st && !timed_out) write_model(addr, exp_be(op, addr), exp_wdata(op, data));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    mem_mem_op = OP_NOP; mem_pc = 32'h1234; mem_mem_addr = 32'h0; mem_mem_data = 32'h0;
    mem_we = 1'b1; mem_write_reg = 5'd7; mem_write_data = 32'h55;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_req", dmem_req, 0);
    check_val("rst_wr", dmem_wr, 0);
    check_val("rst_addr", dmem_addr, 0);
    check_val("rst_wdata", dmem_wdata, 0);
    check_val("rst_be", dmem_be, 0);
    check_val("rst_stall", stall_req, 0);
    check_val("rst_wb_pc", wb_pc, 0);
    check_val("rst_wb_we", wb_we, 0);
    check_val("rst_wb_reg", wb_write_reg, 0);
    check_val("rst_wb_data", wb_write_data, 0);
    check_val("rst_mis", misalign_err, 0);
    check_val("rst_bus", bus_err, 0);
    rst = 1'b0;

    do_op(OP_LW, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
    do_op(OP_SB, 32'h103, 32'h0000_005A, 32'h0, 0);
    do_op(OP_LB, 32'h102, 32'h0, 32'h0080_0000, 1);
    do_op(OP_LBU, 32'h102, 32'h0, 32'h0080_0000, 0);
    do_op(OP_LH, 32'h101, 32'h0, 32'h0, 0);
    do_op(OP_NOP, 32'h0, 32'h0, 32'h0, 0);
    do_op(OP_LHU, 32'h106, 32'h0, 32'h8001_7FFF, 3);
    do_op(OP_SH, 32'h10A, 32'hCAFE_1234, 32'h0, 1);
    do_op(OP_SW, 32'h10E, 32'h1, 32'h0, 0);
    do_op(OP_LW, 32'h120, 32'h0, 32'h0, 1000);

    // Reset while BUSY: request must drop and a late ack must not restart anything.
    n_txn++;
    $display("txn %0d reset during BUSY", n_txn);
    mem_mem_op = OP_LW; mem_mem_addr = 32'h200; mem_we = 1'b1;
    @(posedge clk); #1;
    check_val("rb_req_up", dmem_req, 1);
    rst = 1'b1; drive_nop(1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("rb_req_drop", dmem_req, 0);
    check_val("rb_stall", stall_req, 0);
    check_val("rb_we", wb_we, 0);
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check_val("rb_late_req", dmem_req, 0);
    check_val("rb_late_we", wb_we, 0);
    check_val("rb_late_stall", stall_req, 0);
    check_val("rb_late_buserr", bus_err, 0);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 8));
      a = 32'h100 + 32'($urandom_range(0, 63));
      do_op(op, a, $urandom, read_word(a), int'($urandom_range(0, TO - 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
